conv_seq_ctrl: RTL

- Central sequencer for the 1-D convolution engine (x buffer of N samples, f buffer of M taps, single MAC accumulator, y output stream of N-M+1 results).
- Loads both sample memories through valid/ready slaves and owns all memory addresses and write enables.
- Issues MAC read sequences and drives accumulator clear/enable timed to the 1-cycle memory read latency.
- Runs the y valid/ready master handshake, then returns to loading for the next frame.

---
 rtl/conv_seq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution engine: loads x/f memories, issues MAC reads, streams y results.
// Optional FILTER_REUSE_EN keeps the filter taps loaded after the first frame until reset.
module conv_seq_ctrl #(
   parameter int N    = 128,
   parameter int M    = 32,
   parameter int LOGN = 7,
   parameter int LOGM = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_valid_x,
   output logic            s_ready_x,
   input  logic            s_valid_f,
   output logic            s_ready_f,
   output logic            x_wr_en,
   output logic [LOGN-1:0] x_addr,
   output logic            f_wr_en,
   output logic [LOGM-1:0] f_addr,
   output logic            acc_clr,
   output logic            acc_en,
   output logic            m_valid_y,
   input  logic            m_ready_y,
   output logic            frame_done,
   output logic            busy
);

   typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_t;

   localparam logic [LOGN:0]   X_FULL    = (LOGN+1)'(N);
   localparam logic [LOGM:0]   F_FULL    = (LOGM+1)'(M);
   localparam logic [LOGN-1:0] LAST_BASE = LOGN'(N - M);
   localparam logic [LOGM-1:0] K_LAST    = LOGM'(M - 1);

   state_t          state, state_nxt;
   logic [LOGN:0]   xcnt, xcnt_nxt;
   logic [LOGM:0]   fcnt, fcnt_nxt;
   logic [LOGN-1:0] base, base_nxt;
   logic [LOGM-1:0] k, k_nxt;
   logic            acc_en_q;
   logic            frame_done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOAD;
         xcnt       <= '0;
         fcnt       <= '0;
         base       <= '0;
         k          <= '0;
         acc_en_q   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         xcnt       <= xcnt_nxt;
         fcnt       <= fcnt_nxt;
         base       <= base_nxt;
         k          <= k_nxt;
         // A read issued in MAC this cycle has its data on the memory outputs next cycle
         acc_en_q   <= (state == MAC);
         frame_done <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      xcnt_nxt       = xcnt;
      fcnt_nxt       = fcnt;
      base_nxt       = base;
      k_nxt          = k;
      frame_done_nxt = 1'b0;
      s_ready_x      = 1'b0;
      s_ready_f      = 1'b0;
      x_wr_en        = 1'b0;
      f_wr_en        = 1'b0;
      x_addr         = base + LOGN'(k);
      f_addr         = k;
      acc_clr        = 1'b0;
      acc_en         = 1'b0;
      m_valid_y      = 1'b0;

      case (state)
         LOAD: begin
            s_ready_x = (xcnt < X_FULL);
            x_wr_en   = s_valid_x & s_ready_x;
            x_addr    = xcnt[LOGN-1:0];
            s_ready_f = (fcnt < F_FULL);
            f_wr_en   = s_valid_f & s_ready_f;
            f_addr    = fcnt[LOGM-1:0];
            if (x_wr_en) xcnt_nxt = xcnt + 1'b1;
            if (f_wr_en) fcnt_nxt = fcnt + 1'b1;
            if ((xcnt == X_FULL) && (fcnt == F_FULL)) begin
               state_nxt = MAC;
               base_nxt  = '0;
               k_nxt     = '0;
            end
         end

         MAC: begin
            acc_clr = (k == '0);
            acc_en  = acc_en_q;
            if (k == K_LAST) state_nxt = DRAIN;
            else             k_nxt     = k + 1'b1;
         end

         DRAIN: begin
            acc_en    = 1'b1;
            state_nxt = OUT;
         end

         OUT: begin
            m_valid_y = 1'b1;
            if (m_ready_y) begin
               k_nxt = '0;
               if (base == LAST_BASE) begin
                  state_nxt      = LOAD;
                  frame_done_nxt = 1'b1;
                  xcnt_nxt       = '0;
                  base_nxt       = '0;
`ifdef FILTER_REUSE_EN
                  fcnt_nxt       = fcnt;
`else
                  fcnt_nxt       = '0;
`endif
               end else begin
                  base_nxt  = base + 1'b1;
                  state_nxt = MAC;
               end
            end
         end

         default: state_nxt = LOAD;
      endcase
   end

   assign busy = (state != LOAD);

endmodule
